// File: rtl/arb_mux_pkg.sv
// Shared helpers for the arbitrated N:1 selector: select-width sizing and grant-vector utilities.
// Latency: none (types and pure functions only).
// Backpressure: not applicable.
//
// Grant helpers work on a fixed ARB_MAX_N-bit vector. Callers zero-extend their N-bit
// request vector into it, so N is limited to ARB_MAX_N channels.
package arb_mux_pkg;

  localparam int ARB_MAX_N = 64;

  typedef logic [ARB_MAX_N-1:0] arb_vec_t;

  // Width of a channel index; at least one bit so N = 1 still has a real port.
  function automatic int selw(input int n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

  // Isolates the least-significant set bit. This is the fixed-priority core.
  function automatic arb_vec_t lowest_one(input arb_vec_t v);
    return v & (~v + 1'b1);
  endfunction

  // Encodes a one-hot vector as an index. An all-zero vector gives 0.
  function automatic int onehot_to_idx(input arb_vec_t v);
    int idx;
    idx = 0;
    for (int i = 0; i < ARB_MAX_N; i++)
      if (v[i]) idx = idx | i;
    return idx;
  endfunction

  // Rotates the low n bits right by sh (sh < n), so that bit sh lands at bit 0.
  function automatic arb_vec_t rot_right(input arb_vec_t v, input int sh, input int n);
    arb_vec_t r;
    r = '0;
    for (int i = 0; i < ARB_MAX_N; i++)
      if (i < n) r[i] = v[(i + sh) % n];
    return r;
  endfunction

  // Inverse of rot_right: rotates the low n bits left by sh.
  function automatic arb_vec_t rot_left(input arb_vec_t v, input int sh, input int n);
    arb_vec_t r;
    r = '0;
    for (int i = 0; i < ARB_MAX_N; i++)
      if (i < n) r[(i + sh) % n] = v[i];
    return r;
  endfunction

endpackage

// File: rtl/arb_mux_grant.sv
// Combinational arbiter: turns request bits (and a rotating pointer) into a one-hot grant and its index.
// Latency: combinational, no state.
// Backpressure: none; the caller masks the grant with its own load/flush qualifiers.
//
// Ports: req (N requests), ptr (round-robin start index), grant (one-hot), grant_idx, any (some request).
// Build option ARB_MUX_RR_EN: when defined, the search starts at ptr and wraps.
// Otherwise fixed priority applies, the lowest index wins, and ptr is ignored.
module arb_mux_grant
  import arb_mux_pkg::*;
#(
  parameter int N    = 4,
  parameter int SELW = 2
) (
  input  logic [N-1:0]    req,
  input  logic [SELW-1:0] ptr,
  output logic [N-1:0]    grant,
  output logic [SELW-1:0] grant_idx,
  output logic            any
);

  arb_vec_t req_w;
  arb_vec_t gv;

  always_comb begin
    req_w        = '0;
    req_w[N-1:0] = req;
`ifdef ARB_MUX_RR_EN
    // Rotate so ptr sits at bit 0, pick the lowest, then rotate back.
    gv = rot_left(lowest_one(rot_right(req_w, int'(ptr), N)), int'(ptr), N);
`else
    gv = lowest_one(req_w);
`endif
  end

`ifndef ARB_MUX_RR_EN
  logic unused_ptr;
  assign unused_ptr = ^ptr;
`endif

  assign grant     = gv[N-1:0];
  assign grant_idx = SELW'(onehot_to_idx(gv));
  assign any       = |req;

endmodule

// File: rtl/arb_mux_n_to_1.sv
// Arbitrated, registered N:1 selector. It forwards one winning channel's word and index per cycle.
// Latency: 1 cycle from an accepted input handshake to out_valid.
// Backpressure: single output slot; in_ready stays low while the slot is full and out_ready is low.
//
// Ports: clk, rst (sync, active-high), flush (drops the held word)
//        in_data/in_valid/in_ready: N channels, with channel i at in_data[i*WIDTH +: WIDTH]
//        out_data/out_sel/out_valid/out_ready: registered winner and its channel index
// Build option ARB_MUX_RR_EN: round-robin arbitration with a pointer register; otherwise fixed priority.
module arb_mux_n_to_1
  import arb_mux_pkg::*;
#(
  parameter  int WIDTH = 8,
  parameter  int N     = 4,
  localparam int SELW  = selw(N)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               flush,
  input  logic [N*WIDTH-1:0] in_data,
  input  logic [N-1:0]       in_valid,
  output logic [N-1:0]       in_ready,
  output logic [WIDTH-1:0]   out_data,
  output logic [SELW-1:0]    out_sel,
  output logic               out_valid,
  input  logic               out_ready
);

  logic [N-1:0]     grant;
  logic [SELW-1:0]  grant_idx;
  logic             any;
  logic [SELW-1:0]  ptr;
  logic             load;
  logic             accept_en;
  logic             take;
  logic [WIDTH-1:0] mux_data;

  arb_mux_grant #(
    .N    (N),
    .SELW (SELW)
  ) u_grant (
    .req       (in_valid),
    .ptr       (ptr),
    .grant     (grant),
    .grant_idx (grant_idx),
    .any       (any)
  );

  // The slot can take a new word when it is empty or is being drained this cycle.
  assign load      = ~out_valid | out_ready;
  assign accept_en = load & ~flush & ~rst;
  assign in_ready  = grant & {N{accept_en}};
  assign take      = accept_en & any;

  // The grant is one-hot, so an AND-OR select is enough.
  always_comb begin
    mux_data = '0;
    for (int i = 0; i < N; i++)
      mux_data = mux_data | (in_data[i*WIDTH +: WIDTH] & {WIDTH{grant[i]}});
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid <= 1'b0;
      out_data  <= '0;
      out_sel   <= '0;
    end else if (flush) begin
      out_valid <= 1'b0;
    end else if (load) begin
      if (any) begin
        out_valid <= 1'b1;
        out_data  <= mux_data;
        out_sel   <= grant_idx;
      end else begin
        // Nothing to load: the slot empties, and data/sel keep their last values.
        out_valid <= 1'b0;
      end
    end
  end

`ifdef ARB_MUX_RR_EN
  // The pointer moves one past the channel just served and only changes on an accepted word.
  always_ff @(posedge clk) begin
    if (rst)
      ptr <= '0;
    else if (take)
      ptr <= (int'(grant_idx) == N - 1) ? '0 : grant_idx + 1'b1;
  end
`else
  assign ptr = '0;
  logic unused_take;
  assign unused_take = take;
`endif

endmodule

// File: tb/tb_arb_mux_n_to_1.sv
module tb_arb_mux_n_to_1;

  localparam int N    = 4;
  localparam int W    = 8;
  localparam int SELW = 2;

  logic           clk = 1'b0;
  logic           rst;
  logic           flush;
  logic [N*W-1:0] in_data;
  logic [N-1:0]   in_valid;
  logic [N-1:0]   in_ready;
  logic [W-1:0]   out_data;
  logic [SELW-1:0] out_sel;
  logic           out_valid;
  logic           out_ready;

  always #5 clk = ~clk;

  arb_mux_n_to_1 #(.WIDTH(W), .N(N)) dut (
    .clk       (clk),
    .rst       (rst),
    .flush     (flush),
    .in_data   (in_data),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .out_data  (out_data),
    .out_sel   (out_sel),
    .out_valid (out_valid),
    .out_ready (out_ready)
  );

  typedef struct packed {
    logic [W-1:0]    d;
    logic [SELW-1:0] s;
  } word_t;

  // The scoreboard queue holds the word the output slot should be holding (0 or 1 entries).
  word_t           q[$];
  logic [W-1:0]    hold_d = '0;
  logic [SELW-1:0] hold_s = '0;
  int              rr_ptr = 0;
  bit              mon_on = 1'b0;
  int              total  = 0;
  int              bad    = 0;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at time %0t", name, got, exp, $time);
    end
  endtask

  // Reference arbitration: scan the valid channels in priority order.
  function automatic int pick(input logic [N-1:0] v);
    int start;
    start = 0;
`ifdef ARB_MUX_RR_EN
    start = rr_ptr;
`endif
    for (int k = 0; k < N; k++)
      if (v[(start + k) % N]) return (start + k) % N;
    return -1;
  endfunction

  function automatic logic [N*W-1:0] dv(input logic [W-1:0] c0, input logic [W-1:0] c1,
                                        input logic [W-1:0] c2, input logic [W-1:0] c3);
    return {c3, c2, c1, c0};
  endfunction

  // One clock cycle of stimulus. in_ready is checked here; the accepted word goes to the scoreboard.
  task automatic step(input bit r, input bit f, input logic [N-1:0] v,
                      input logic [N*W-1:0] d, input bit ordy);
    int           g;
    logic [N-1:0] exp_rdy;
    bit           load;
    word_t        w;
    @(negedge clk);
    rst       = r;
    flush     = f;
    in_valid  = v;
    in_data   = d;
    out_ready = ordy;
    #1;
    load = (q.size() == 0) || ordy;
    g    = (r || f || !load) ? -1 : pick(v);
    exp_rdy = '0;
    if (g >= 0) exp_rdy[g] = 1'b1;
    chk("in_ready", 32'(in_ready), 32'(exp_rdy));
    @(posedge clk);
    mon_on = 1'b1;
    if (r) begin
      q.delete();
      hold_d = '0;
      hold_s = '0;
      rr_ptr = 0;
    end else if (f) begin
      q.delete();
    end else if (g >= 0) begin
      w.d = d[g*W +: W];
      w.s = SELW'(g);
      q.push_back(w);
      hold_d = w.d;
      hold_s = w.s;
      rr_ptr = (g + 1) % N;
    end
  endtask

  // Monitor: compares the output slot against the scoreboard and retires consumed words.
  initial begin
    forever begin
      @(negedge clk);
      #2;
      if (mon_on) begin
        chk("out_valid", 32'(out_valid), 32'(q.size() != 0));
        if (out_valid && q.size() != 0) begin
          chk("out_data", 32'(out_data), 32'(q[0].d));
          chk("out_sel", 32'(out_sel), 32'(q[0].s));
          if (out_ready && !flush && !rst) void'(q.pop_front());
        end else if (!out_valid) begin
          chk("hold_data", 32'(out_data), 32'(hold_d));
          chk("hold_sel", 32'(out_sel), 32'(hold_s));
        end
      end
    end
  end

  initial begin
    rst = 1'b1; flush = 1'b0; in_valid = '0; in_data = '0; out_ready = 1'b0;

    // Reset with every channel requesting.
    step(1'b1, 1'b0, 4'hF, dv(8'h01, 8'h02, 8'h03, 8'h04), 1'b1);
    step(1'b1, 1'b0, 4'hF, dv(8'h01, 8'h02, 8'h03, 8'h04), 1'b1);

    // All channels valid and streaming.
    for (int i = 0; i < 6; i++)
      step(1'b0, 1'b0, 4'hF, dv(8'h10, 8'h11, 8'h12, 8'h13), 1'b1);

    // Channels 1 and 3 compete.
    for (int i = 0; i < 4; i++)
      step(1'b0, 1'b0, 4'b1010, dv(8'h00, 8'hA1, 8'h00, 8'hA3), 1'b1);
    step(1'b0, 1'b0, 4'b0000, '0, 1'b1);

    // Back-pressure: 0x55 is held, then 0x66 replaces it with no bubble.
    step(1'b0, 1'b0, 4'b0001, dv(8'h55, 8'h00, 8'h00, 8'h00), 1'b1);
    for (int i = 0; i < 3; i++)
      step(1'b0, 1'b0, 4'b0100, dv(8'h00, 8'h00, 8'h66, 8'h00), 1'b0);
    step(1'b0, 1'b0, 4'b0100, dv(8'h00, 8'h00, 8'h66, 8'h00), 1'b1);
    step(1'b0, 1'b0, 4'b0000, '0, 1'b1);

    // Flush while ch0 requests: 0x77 is dropped and ch0 waits a cycle.
    step(1'b0, 1'b0, 4'b0001, dv(8'h77, 8'h00, 8'h00, 8'h00), 1'b1);
    step(1'b0, 1'b1, 4'b0001, dv(8'h78, 8'h00, 8'h00, 8'h00), 1'b0);
    step(1'b0, 1'b0, 4'b0001, dv(8'h78, 8'h00, 8'h00, 8'h00), 1'b1);
    step(1'b0, 1'b0, 4'b0000, '0, 1'b1);

    // Idle drain: a single word, then the slot empties and holds 0x3C.
    step(1'b0, 1'b0, 4'b0001, dv(8'h3C, 8'h00, 8'h00, 8'h00), 1'b1);
    for (int i = 0; i < 3; i++)
      step(1'b0, 1'b0, 4'b0000, '0, 1'b1);

    // Random traffic with occasional flush and reset.
    for (int i = 0; i < 3000; i++)
      step(bit'($urandom_range(63) == 0), bit'($urandom_range(15) == 0),
           4'($urandom), $urandom, bit'($urandom_range(3) != 0));

    step(1'b0, 1'b0, 4'b0000, '0, 1'b1);
    step(1'b0, 1'b0, 4'b0000, '0, 1'b1);
    @(negedge clk);
    #3;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/arb_mux_n_to_1.md
# arb_mux_n_to_1

Parametrised, registered N-to-1 data selector with valid/ready handshake and built-in arbitration. Replaces hard-wired 2:1 byte muxes wherever several producers share one datapath port. Typical sharers are ALU result, load data and immediate feeding the writeback/operand bus of the 3-stage processor. Arbitrates among requesting inputs, registers the winner's data plus its index, and sustains one transfer per cycle under back-pressure.

## Interface
Parameters:
- WIDTH, 8: data bits per channel (≥1)
- N, 4: number of input channels (≥1)

Ports:
- clk, input, 1: single clock, all state on rising edge
- rst, input, 1: reset, synchronous, active-high
- flush, input, 1: synchronous discard of the held output word
- in_data, input, N*WIDTH: channel i occupies bits [i*WIDTH +: WIDTH]
- in_valid, input, N: channel i has a word
- in_ready, output, N: channel i's word is accepted this cycle
- out_data, output, WIDTH: registered selected word
- out_sel, output, SELW: index of the channel that supplied out_data; SELW = max(1, clog2(N))
- out_valid, output, 1: out_data/out_sel hold a word
- out_ready, input, 1: consumer takes the word this cycle

## Operation
- Output stage is a single register slot: out_data, out_sel, out_valid.
- load = ~out_valid | out_ready. Arbitration runs only when load = 1; otherwise all in_ready = 0.
- Grant is one-hot over in_valid. in_ready[i] = load & grant[i]. At most one in_ready is high per cycle, and never when in_valid[i] = 0.
- On load with any in_valid:
  - out_data ← granted word
  - out_sel ← granted index
  - out_valid ← 1
- On load with no in_valid: out_valid ← 0; out_data and out_sel hold their values.
- Arbitration, default: fixed priority, lowest index wins.
- flush = 1:
  - out_valid ← 0
  - all in_ready forced 0 that cycle, so nothing is accepted
  - arbitration pointer unchanged
- rst = 1:
  - out_valid = 0, out_data = 0, out_sel = 0, pointer = 0
  - in_ready = 0 while rst is high
  - any word in flight is dropped
  - rst has priority over flush
- N = 1: grant = in_valid[0]. out_sel is constant 0.
- Word order from a single channel is preserved. No word is duplicated or lost except by flush or rst.

## Timing
- Latency: in_valid/in_ready handshake at edge k produces out_valid = 1 with that word after edge k, i.e. visible in cycle k+1.
- Throughput: 1 word/cycle when out_ready is held 1.
- Drain and load in the same cycle (out_valid & out_ready & a requester): the new word replaces the old with no bubble.
- in_ready depends combinationally on in_valid, out_valid, out_ready, flush, rst and the pointer. out_* are pure register outputs.
- Producers must hold in_valid and in_data stable until in_ready; the block does not require this for correctness.

## Configuration
- ARB_MUX_RR_EN defined: round-robin arbitration.
  - Pointer register p (SELW bits, reset 0).
  - Search starts at index p, wraps at N-1 → 0.
  - After each accepted word from channel g, p ← (g+1) mod N.
  - With no accepted word, p holds.
- ARB_MUX_RR_EN undefined: fixed priority as above; no pointer register is synthesised.

## Structure
- Package arb_mux_pkg:
  - clog2-based SELW function
  - grant-vector helper functions (onehot-to-index, rotate-left/right by index)
- Sub-module arb_mux_grant:
  - combinational requests + pointer → one-hot grant and index
  - fixed-priority or round-robin, selected by ARB_MUX_RR_EN
- Top level holds the output register, load/flush logic, the pointer register and the data AND-OR select.

## Test plan
- Reset: rst = 1 for 2 cycles with all in_valid = 1 → in_ready = 0, out_valid = 0, out_data = 0, out_sel = 0; first word appears the cycle after rst falls.
- Fixed priority (macro off), N=4, WIDTH=8: in_valid = 4'b1010, data ch1 = 8'hA1, ch3 = 8'hA3, out_ready = 1 → out sequence A1, A1, … with out_sel = 1; in_ready[3] never high while ch1 is valid.
- Round-robin (macro on): all four valid continuously, data = 8'h10+i, out_ready = 1 → out_sel 0,1,2,3,0 on consecutive cycles; pointer wraps 3→0.
- Back-pressure: word 8'h55 held with out_ready = 0 for 3 cycles → out_data stable at 55, all in_ready = 0; on out_ready = 1 with ch2 valid = 8'h66 → next cycle out_data = 66, no bubble.
- Flush: out_valid = 1 with 8'h77 and flush = 1 while ch0 is valid → next cycle out_valid = 0, ch0 not accepted; following cycle ch0's word appears.
- Idle drain: single word 8'h3C on ch0, then all in_valid = 0 with out_ready = 1 → out_valid 1 for one cycle, then 0; out_data holds 3C.
